mbm_mul_arbiter: RTL and testbench

Shares one 16x16 signed radix-4 Booth multiplier core (mbmt1) among NREQ requesters using round-robin arbitration.
Two-stage pipeline: arbitrated operand register, then multiplier core into a registered result.
One result per cycle, tagged with the requester index, with valid/ready backpressure on both sides.
Sits between the DSP-side operand producers and the single shared Booth datapath.

---
 rtl/mbm_mul_arbiter.sv | 145 ++++++++++++++
 tb/tb_mbm_mul_arbiter.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/mbm_mul_arbiter.sv
// rtl/mbm_mul_arbiter.sv - round-robin shared radix-4 Booth 16x16 multiplier, optional MBM_ARB_PRIO_EN
module mbm_mul_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [16*NREQ-1:0]   req_a,
    input  logic [16*NREQ-1:0]   req_b,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [IDW-1:0]       rsp_id,
    output logic [31:0]          rsp_product
);

    logic            s1_valid;
    logic [15:0]     s1_a;
    logic [15:0]     s1_b;
    logic [IDW-1:0]  s1_id;
    logic [IDW-1:0]  ptr;
    logic [IDW-1:0]  gnt;
    logic            found;
    logic            accept;
    logic            s2_load;
    logic            s1_free;
    logic [15:0]     sel_a;
    logic [15:0]     sel_b;
    logic [31:0]     prod;

    // Radix-4 Booth: eight recoded digits in {-2..+2}, summed modulo 2^32.
    function automatic logic [31:0] mbmt1(input logic [15:0] multiplier,
                                          input logic [15:0] multiplicand);
        logic [16:0] bx;
        logic [31:0] ae;
        logic [31:0] pp;
        logic [31:0] acc;
        bx  = {multiplier, 1'b0};
        ae  = {{16{multiplicand[15]}}, multiplicand};
        acc = '0;
        for (int i = 0; i < 8; i++) begin
            case (bx[2*i +: 3])
                3'b001, 3'b010: pp = ae;
                3'b011:         pp = ae << 1;
                3'b100:         pp = -(ae << 1);
                3'b101, 3'b110: pp = -ae;
                default:        pp = '0;
            endcase
            acc = acc + (pp << (2*i));
        end
        return acc;
    endfunction

    assign s2_load = s1_valid & (~rsp_valid | rsp_ready);
    assign s1_free = ~s1_valid | s2_load;
    assign accept  = found & s1_free & ~flush & ~rst;
    assign prod    = mbmt1(s1_b, s1_a);

    always_comb begin
        int idx;
`ifdef MBM_ARB_PRIO_EN
        int start;
`endif
        found = 1'b0;
        gnt   = '0;
        idx   = 0;
`ifdef MBM_ARB_PRIO_EN
        start = (ptr == '0) ? 1 : int'(ptr);
        if (req_valid[0]) begin
            found = 1'b1;
        end else begin
            // Index 0 is excluded from the rotation; wrap within 1..NREQ-1.
            for (int k = 0; k < NREQ-1; k++) begin
                idx = start + k;
                if (idx >= NREQ) idx = idx - (NREQ - 1);
                if (!found && req_valid[idx[IDW-1:0]]) begin
                    found = 1'b1;
                    gnt   = idx[IDW-1:0];
                end
            end
        end
`else
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!found && req_valid[idx[IDW-1:0]]) begin
                found = 1'b1;
                gnt   = idx[IDW-1:0];
            end
        end
`endif
    end

    always_comb begin
        req_ready = '0;
        sel_a     = '0;
        sel_b     = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt == IDW'(i)) begin
                sel_a = req_a[16*i +: 16];
                sel_b = req_b[16*i +: 16];
                if (accept) req_ready[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid    <= 1'b0;
            s1_a        <= '0;
            s1_b        <= '0;
            s1_id       <= '0;
            ptr         <= '0;
            rsp_valid   <= 1'b0;
            rsp_id      <= '0;
            rsp_product <= '0;
        end else if (flush) begin
            s1_valid  <= 1'b0;
            rsp_valid <= 1'b0;
        end else begin
            if (s2_load) begin
                rsp_valid   <= 1'b1;
                rsp_id      <= s1_id;
                rsp_product <= prod;
            end else if (rsp_ready) begin
                rsp_valid <= 1'b0;
            end
            if (s1_free) s1_valid <= accept;
            if (accept) begin
                s1_a  <= sel_a;
                s1_b  <= sel_b;
                s1_id <= gnt;
`ifdef MBM_ARB_PRIO_EN
                if (gnt != '0)
                    ptr <= (gnt == IDW'(NREQ-1)) ? '0 : gnt + 1'b1;
`else
                ptr <= (gnt == IDW'(NREQ-1)) ? '0 : gnt + 1'b1;
`endif
            end
        end
    end

endmodule

// File: tb/tb_mbm_mul_arbiter.sv
// tb/tb_mbm_mul_arbiter.sv - scoreboard bench for mbm_mul_arbiter (MBM_ARB_PRIO_EN selects prio tests)
module tb_mbm_mul_arbiter;

    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 flush;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [16*NREQ-1:0]   req_a;
    logic [16*NREQ-1:0]   req_b;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [IDW-1:0]       rsp_id;
    logic [31:0]          rsp_product;

    typedef struct {
        int          id;
        logic [31:0] p;
    } exp_t;

    exp_t         sb[$];
    int           gq[$];
    logic [31:0]  exp_p [NREQ];
    logic [NREQ-1:0] accepted = '0;
    logic [NREQ-1:0] oneshot  = '0;
    int           checks = 0;
    int           errors = 0;
    int           acc_cnt = 0;

    mbm_mul_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_product(rsp_product)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic set_op(input int i, input logic [15:0] a, input logic [15:0] b,
                          input logic [31:0] p);
        req_a[16*i +: 16] = a;
        req_b[16*i +: 16] = b;
        exp_p[i] = p;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        req_valid = req_valid & ~(oneshot & accepted);
    endtask

    task automatic wait_gq();
        int n = 0;
        while (gq.size() > 0 && n < 60) begin
            tick();
            n++;
        end
        chk("grant_timeout", gq.size(), 0);
    endtask

    // Acceptance monitor: records handshakes and queues their expected results.
    always @(negedge clk) begin
        accepted = '0;
        if (!rst) begin
            chk("ready_onehot", 32'($countones(req_ready) <= 1), 1);
            for (int i = 0; i < NREQ; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    exp_t e;
                    accepted[i] = 1'b1;
                    acc_cnt++;
                    e.id = i;
                    e.p  = exp_p[i];
                    sb.push_back(e);
                    if (gq.size() > 0) chk("grant_order", i, gq.pop_front());
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rsp: got id %0d product %h, expected none", rsp_id, rsp_product);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("rsp_id", 32'(rsp_id), e.id);
                chk("rsp_product", rsp_product, e.p);
            end
        end
    end

    initial begin
        rst       = 1'b1;
        flush     = 1'b0;
        req_valid = '1;
        rsp_ready = 1'b1;
        req_a     = '0;
        req_b     = '0;
        for (int i = 0; i < NREQ; i++) exp_p[i] = '0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_rsp_id", 32'(rsp_id), 0);
        chk("rst_rsp_product", rsp_product, 0);
        chk("rst_req_ready", 32'(req_ready), 0);
        @(posedge clk);
        #1;
        rst       = 1'b0;
        req_valid = '0;

        set_op(0, 16'h8000, 16'h8000, 32'h4000_0000);
        set_op(1, 16'h7FFF, 16'h8000, 32'hC000_8000);
        set_op(3, 16'd123, -16'sd456, -32'sd56088);

`ifndef MBM_ARB_PRIO_EN
        // Single request, latency and pointer advance
        set_op(2, -16'sd7, 16'd300, -32'sd2100);
        oneshot   = '1;
        req_valid = 4'b0100;
        gq.push_back(2);
        @(negedge clk);
        chk("single_ready", 32'(req_ready), 32'h4);
        tick();
        @(negedge clk);
        chk("lat_edge1", 32'(rsp_valid), 0);
        tick();
        @(negedge clk);
        chk("lat_edge2", 32'(rsp_valid), 1);
        tick();

        // Continuous round robin starting from ptr=3
        set_op(2, 16'h1234, -16'sd5, -32'sd23300);
        oneshot   = '0;
        req_valid = '1;
        foreach (gq[i]) gq.delete();
        gq.push_back(3); gq.push_back(0); gq.push_back(1); gq.push_back(2);
        gq.push_back(3); gq.push_back(0); gq.push_back(1); gq.push_back(2);
        wait_gq();
        req_valid = '0;
        repeat (3) tick();
        chk("drain_cont", sb.size(), 0);

        // Backpressure: two accepted, then stall with stable outputs
        rsp_ready = 1'b0;
        req_valid = '1;
        acc_cnt   = 0;
        gq.push_back(3); gq.push_back(0);
        repeat (5) tick();
        @(negedge clk);
        chk("bp_accepts", acc_cnt, 2);
        chk("bp_ready", 32'(req_ready), 0);
        chk("bp_rsp_valid", 32'(rsp_valid), 1);
        chk("bp_rsp_id", 32'(rsp_id), 3);
        chk("bp_rsp_product", rsp_product, -32'sd56088);
        repeat (2) tick();
        @(negedge clk);
        chk("bp_hold_id", 32'(rsp_id), 3);
        chk("bp_hold_product", rsp_product, -32'sd56088);
        tick();
        req_valid = '0;
        rsp_ready = 1'b1;
        repeat (3) tick();
        chk("drain_bp", sb.size(), 0);

        // Flush with both stages full; pointer must hold
        rsp_ready = 1'b0;
        req_valid = '1;
        gq.push_back(1); gq.push_back(2);
        repeat (3) tick();
        flush = 1'b1;
        sb.delete();
        @(negedge clk);
        chk("flush_no_accept", 32'(req_ready), 0);
        tick();
        flush     = 1'b0;
        oneshot   = '1;
        req_valid = 4'b1010;
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("flush_rsp_valid", 32'(rsp_valid), 0);
        gq.push_back(3); gq.push_back(1);
        wait_gq();
        repeat (4) tick();
        chk("drain_flush", sb.size(), 0);

        // Async reset mid-stream
        oneshot   = '0;
        req_valid = '1;
        repeat (3) tick();
        #2;
        rst = 1'b1;
        #1;
        chk("arst_rsp_valid", 32'(rsp_valid), 0);
        chk("arst_rsp_product", rsp_product, 0);
        chk("arst_rsp_id", 32'(rsp_id), 0);
        chk("arst_req_ready", 32'(req_ready), 0);
        sb.delete();
        gq.delete();
        tick();
        rst = 1'b0;
        gq.push_back(0); gq.push_back(1);
        wait_gq();
        req_valid = '0;
        repeat (4) tick();
        chk("drain_arst", sb.size(), 0);
`else
        set_op(2, 16'h1234, -16'sd5, -32'sd23300);
        oneshot   = '0;
        req_valid = 4'b1001;
        gq.push_back(0); gq.push_back(0); gq.push_back(0); gq.push_back(0);
        wait_gq();
        req_valid = 4'b1010;
        gq.push_back(1); gq.push_back(3); gq.push_back(1); gq.push_back(3);
        wait_gq();
        req_valid = '0;
        repeat (4) tick();
        chk("drain_prio", sb.size(), 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
